traffic_ctrl: RTL and testbench



---
 rtl/traffic_ctrl_pkg.sv | 30 +++
 rtl/traffic_ctrl_lane_mover.sv | 47 ++++
 rtl/traffic_ctrl.sv | 109 ++++++++++
 tb/tb_traffic_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_ctrl_pkg.sv
// Shared geometry, FSM state type and the car/raccoon rectangle overlap test
// for the road-crossing traffic engine.
package traffic_ctrl_pkg;

    localparam int GRID_HEIGHT    = 32;
    localparam int H_ACTIVE_VIDEO = 640;
    localparam int CAR_WIDTH      = 64;
    localparam int CAR_HEIGHT     = 32;
    localparam int PLAYER_WIDTH   = 32;
    localparam int PLAYER_HEIGHT  = 32;

    typedef enum logic [1:0] {
        TRAFFIC_IDLE = 2'd0,
        TRAFFIC_RUN  = 2'd1,
        TRAFFIC_HIT  = 2'd2
    } traffic_state_t;

    // Widened to 11 bits so the right/bottom edge sums never wrap.
    function automatic logic overlaps(input logic [9:0] rx, input logic [9:0] ry,
                                      input logic [9:0] cx, input logic [9:0] cy);
        logic [10:0] rxw, ryw, cxw, cyw;
        rxw = {1'b0, rx};
        ryw = {1'b0, ry};
        cxw = {1'b0, cx};
        cyw = {1'b0, cy};
        return (rxw < cxw + 11'(CAR_WIDTH))    && (cxw < rxw + 11'(PLAYER_WIDTH)) &&
               (ryw < cyw + 11'(CAR_HEIGHT))   && (cyw < ryw + 11'(PLAYER_HEIGHT));
    endfunction

endpackage

// File: rtl/traffic_ctrl_lane_mover.sv
// One car's horizontal position: steps SPEED pixels per frame tick in direction
// DIR and wraps around the 640-pixel active width.
module lane_mover #(
    parameter int SPEED   = 1,
    parameter int DIR     = 0,
    parameter int START_X = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       reload,
    output logic [9:0] x
);
    import traffic_ctrl_pkg::*;

    localparam logic [10:0] STEP  = 11'(SPEED);
    localparam logic [10:0] WIDTH = 11'(H_ACTIVE_VIDEO);
    localparam logic [9:0]  START = 10'(START_X);

    logic [10:0] x_wide;
    logic [9:0]  x_next;

    assign x_wide = {1'b0, x};

    always_comb begin
        x_next = x;
        if (DIR == 0) begin
            if (x_wide + STEP >= WIDTH)
                x_next = 10'(x_wide + STEP - WIDTH);
            else
                x_next = 10'(x_wide + STEP);
        end else begin
            if (x_wide < STEP)
                x_next = 10'(x_wide + WIDTH - STEP);
            else
                x_next = 10'(x_wide - STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || reload)
            x <= START;
        else if (tick)
            x <= x_next;
    end

endmodule

// File: rtl/traffic_ctrl.sv
// Per-frame traffic engine: moves three cars once per frame, detects a
// raccoon/car overlap and freezes the scene until the hit is cleared.
module traffic_ctrl #(
    parameter int FRAME_CYCLES = 420000,
    parameter int SPEED_1      = 2,
    parameter int SPEED_2      = 3,
    parameter int SPEED_3      = 1,
    parameter int DIR_1        = 0,
    parameter int DIR_2        = 1,
    parameter int DIR_3        = 0,
    parameter int START_X_1    = 0,
    parameter int START_X_2    = 320,
    parameter int START_X_3    = 160,
    parameter int LANE_1       = 3,
    parameter int LANE_2       = 5,
    parameter int LANE_3       = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clearHit,
    input  logic [9:0] raccoonX,
    input  logic [9:0] raccoonY,
    output logic [9:0] carX_1,
    output logic [9:0] carY_1,
    output logic [9:0] carX_2,
    output logic [9:0] carY_2,
    output logic [9:0] carX_3,
    output logic [9:0] carY_3,
    output logic       frameStrobe,
    output logic       hit,
    output logic       hitPulse
);
    import traffic_ctrl_pkg::*;

    localparam int             CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    traffic_state_t   state;
    logic [CNT_W-1:0] frame_cnt;
    logic             overlap;
    logic             frame_tick;
    logic             reload;

    assign overlap = overlaps(raccoonX, raccoonY, carX_1, carY_1) |
                     overlaps(raccoonX, raccoonY, carX_2, carY_2) |
                     overlaps(raccoonX, raccoonY, carX_3, carY_3);

    // A collision in the tick cycle suppresses the move entirely.
    assign frame_tick = (state == TRAFFIC_RUN) && enable && !overlap && (frame_cnt == LAST);
    assign reload     = (state == TRAFFIC_HIT) && clearHit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= TRAFFIC_IDLE;
            frame_cnt   <= '0;
            hit         <= 1'b0;
            hitPulse    <= 1'b0;
            frameStrobe <= 1'b0;
            carY_1      <= 10'(LANE_1 * GRID_HEIGHT);
            carY_2      <= 10'(LANE_2 * GRID_HEIGHT);
            carY_3      <= 10'(LANE_3 * GRID_HEIGHT);
        end else begin
            hitPulse    <= 1'b0;
            frameStrobe <= 1'b0;
            case (state)
                TRAFFIC_IDLE: begin
                    if (enable)
                        state <= TRAFFIC_RUN;
                end
                TRAFFIC_RUN: begin
                    if (overlap) begin
                        state     <= TRAFFIC_HIT;
                        hit       <= 1'b1;
                        hitPulse  <= 1'b1;
                        frame_cnt <= '0;
                    end else if (!enable) begin
                        state <= TRAFFIC_IDLE;
                    end else if (frame_tick) begin
                        frame_cnt   <= '0;
                        frameStrobe <= 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                TRAFFIC_HIT: begin
                    if (clearHit) begin
                        hit   <= 1'b0;
                        state <= enable ? TRAFFIC_RUN : TRAFFIC_IDLE;
                    end
                end
                default: state <= TRAFFIC_IDLE;
            endcase
        end
    end

    lane_mover #(.SPEED(SPEED_1), .DIR(DIR_1), .START_X(START_X_1)) u_lane_1 (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .reload(reload), .x(carX_1)
    );

    lane_mover #(.SPEED(SPEED_2), .DIR(DIR_2), .START_X(START_X_2)) u_lane_2 (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .reload(reload), .x(carX_2)
    );

    lane_mover #(.SPEED(SPEED_3), .DIR(DIR_3), .START_X(START_X_3)) u_lane_3 (
        .clk(clk), .rst_n(rst_n), .tick(frame_tick), .reload(reload), .x(carX_3)
    );

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: two instances (default starts and
// edge-wrapping starts) tracked cycle by cycle against a frame-level game model.
module tb_traffic_ctrl;

    localparam int FRAME = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clearHit = 1'b0;
    logic [9:0] raccoonX = 10'd0;
    logic [9:0] raccoonY = 10'd448;

    logic [9:0] ax [3];
    logic [9:0] ay [3];
    logic [9:0] bx [3];
    logic [9:0] by [3];
    logic       a_strobe, a_hit, a_pulse;
    logic       b_strobe, b_hit, b_pulse;

    int checks = 0;
    int errors = 0;

    int startX [2][3] = '{'{0, 320, 160}, '{638, 1, 160}};
    int speed  [3]    = '{2, 3, 1};
    int dirLeft[3]    = '{0, 1, 0};
    int laneY  [3]    = '{96, 160, 288};

    int mx     [2][3];
    int mCnt   [2];
    bit mRun   [2];
    bit mHit   [2];
    bit mStrobe[2];
    bit mPulse [2];

    traffic_ctrl #(.FRAME_CYCLES(FRAME)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clearHit(clearHit),
        .raccoonX(raccoonX), .raccoonY(raccoonY),
        .carX_1(ax[0]), .carY_1(ay[0]), .carX_2(ax[1]), .carY_2(ay[1]),
        .carX_3(ax[2]), .carY_3(ay[2]),
        .frameStrobe(a_strobe), .hit(a_hit), .hitPulse(a_pulse)
    );

    traffic_ctrl #(.FRAME_CYCLES(FRAME), .START_X_1(638), .START_X_2(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clearHit(clearHit),
        .raccoonX(raccoonX), .raccoonY(raccoonY),
        .carX_1(bx[0]), .carY_1(by[0]), .carX_2(bx[1]), .carY_2(by[1]),
        .carX_3(bx[2]), .carY_3(by[2]),
        .frameStrobe(b_strobe), .hit(b_hit), .hitPulse(b_pulse)
    );

    always #5 clk = ~clk;

    function automatic bit touches(int rx, int ry, int cx, int cy);
        return (rx < cx + 64) && (cx < rx + 32) && (ry < cy + 32) && (cy < ry + 32);
    endfunction

    // Game rules at frame level: mode flags, a run-cycle count and modular car positions.
    task automatic modelStep(input int i);
        bit ovl = 1'b0;
        mStrobe[i] = 1'b0;
        mPulse[i]  = 1'b0;
        if (!rst_n) begin
            mRun[i] = 1'b0;
            mHit[i] = 1'b0;
            mCnt[i] = 0;
            for (int c = 0; c < 3; c++) mx[i][c] = startX[i][c];
        end else if (mHit[i]) begin
            if (clearHit) begin
                mHit[i] = 1'b0;
                mRun[i] = enable;
                mCnt[i] = 0;
                for (int c = 0; c < 3; c++) mx[i][c] = startX[i][c];
            end
        end else if (!mRun[i]) begin
            if (enable) mRun[i] = 1'b1;
        end else begin
            for (int c = 0; c < 3; c++)
                if (touches(int'(raccoonX), int'(raccoonY), mx[i][c], laneY[c])) ovl = 1'b1;
            if (ovl) begin
                mHit[i]   = 1'b1;
                mPulse[i] = 1'b1;
                mRun[i]   = 1'b0;
                mCnt[i]   = 0;
            end else if (!enable) begin
                mRun[i] = 1'b0;
            end else if (mCnt[i] == FRAME - 1) begin
                mCnt[i]    = 0;
                mStrobe[i] = 1'b1;
                for (int c = 0; c < 3; c++)
                    mx[i][c] = dirLeft[c] ? (mx[i][c] - speed[c] + 640) % 640
                                          : (mx[i][c] + speed[c]) % 640;
            end else begin
                mCnt[i] = mCnt[i] + 1;
            end
        end
    endtask

    function automatic int obsX(input int i, input int c);
        return (i == 0) ? int'(ax[c]) : int'(bx[c]);
    endfunction

    function automatic int obsY(input int i, input int c);
        return (i == 0) ? int'(ay[c]) : int'(by[c]);
    endfunction

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) begin
                checkValue($sformatf("inst%0d carX_%0d", i, c + 1), obsX(i, c), mx[i][c]);
                checkValue($sformatf("inst%0d carY_%0d", i, c + 1), obsY(i, c), laneY[c]);
            end
            checkValue($sformatf("inst%0d frameStrobe", i),
                       int'(i == 0 ? a_strobe : b_strobe), int'(mStrobe[i]));
            checkValue($sformatf("inst%0d hit", i),
                       int'(i == 0 ? a_hit : b_hit), int'(mHit[i]));
            checkValue($sformatf("inst%0d hitPulse", i),
                       int'(i == 0 ? a_pulse : b_pulse), int'(mPulse[i]));
        end
    endtask

    task automatic applyStimulus(input bit rn, input bit en, input bit clr,
                                 input int rx, input int ry);
        rst_n    = rn;
        enable   = en;
        clearHit = clr;
        raccoonX = 10'(rx);
        raccoonY = 10'(ry);
    endtask

    task automatic stepCycles(input int n);
        for (int k = 0; k < n; k++) begin
            modelStep(0);
            modelStep(1);
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        // Reset held for two cycles.
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 448);
        stepCycles(2);
        checkValue("reset carX_1", int'(ax[0]), 0);
        checkValue("reset carX_2", int'(ax[1]), 320);
        checkValue("reset carX_3", int'(ax[2]), 160);
        checkValue("reset carY_3", int'(ay[2]), 288);
        checkValue("reset hit", int'(a_hit), 0);

        // Free run, with the wrap instance checked after its first frame.
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 448);
        stepCycles(9);
        checkValue("wrap right carX_1", int'(bx[0]), 0);
        checkValue("wrap left carX_2", int'(bx[1]), 638);
        checkValue("first frameStrobe", int'(a_strobe), 1);
        stepCycles(16);
        checkValue("3 frames carX_1", int'(ax[0]), 6);
        checkValue("3 frames carX_2", int'(ax[1]), 311);
        checkValue("3 frames carX_3", int'(ax[2]), 163);

        // Collision with car 1, then a long frozen stretch.
        applyStimulus(1'b1, 1'b1, 1'b0, 40, 96);
        stepCycles(1);
        checkValue("collision hit", int'(a_hit), 1);
        checkValue("collision hitPulse", int'(a_pulse), 1);
        stepCycles(1);
        checkValue("hitPulse one cycle", int'(a_pulse), 0);
        stepCycles(40);
        checkValue("frozen carX_2", int'(ax[1]), 311);

        // Clear the hit with the raccoon out of the way.
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 448);
        stepCycles(1);
        checkValue("clear carX_1", int'(ax[0]), 0);
        checkValue("clear carX_2", int'(ax[1]), 320);
        checkValue("clear hit", int'(a_hit), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 448);
        stepCycles(7);
        checkValue("no early move", int'(ax[0]), 0);
        stepCycles(1);
        checkValue("first move after clear", int'(ax[0]), 2);

        // Pause at count 5, resume, then reset mid-frame.
        stepCycles(5);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 448);
        stepCycles(4);
        checkValue("paused carX_1", int'(ax[0]), 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 448);
        stepCycles(4);
        checkValue("resumed tick carX_1", int'(ax[0]), 4);
        stepCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 448);
        stepCycles(1);
        checkValue("mid reset carX_1", int'(ax[0]), 0);
        checkValue("mid reset carX_2", int'(ax[1]), 320);

        // Randomized play against the model.
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 448);
        for (int r = 0; r < 1000; r++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            enable   = ($urandom_range(0, 9) != 0);
            clearHit = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) begin
                raccoonX = 10'($urandom_range(0, 639));
                raccoonY = 10'($urandom_range(0, 479));
            end
            stepCycles(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
